// File: rtl/iob_cache_axi_resp_pkg.sv
`default_nettype none
// Shared state encoding, response code and beat-size helper for iob_cache_axi_resp.
package iob_cache_axi_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_WR_B = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  localparam logic [1:0] OKAY = 2'b00;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cache_axi_resp_ctr.sv
`default_nettype none
// Burst address incrementer and remaining-beat down-counter for iob_cache_axi_resp.
module iob_cache_axi_resp_ctr #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int STEP   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              addr_inc,
  input  logic              cnt_dec,
  output logic [ADDR_W-1:0] addr,
  output logic              cnt_zero
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [LEN_W-1:0] cnt;

  // Address wraps modulo 2^ADDR_W through plain unsigned overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= load_len;
    end else begin
      if (addr_inc) addr <= addr + STEP_V;
      if (cnt_dec)  cnt  <= cnt - LEN_W'(1);
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/iob_cache_axi_resp.sv
`default_nettype none
// AXI4 burst responder replaying each full-width beat as one native iob request.
// One transaction at a time; AW is preferred over AR when both are pending.
module iob_cache_axi_resp
  import iob_cache_axi_resp_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic                    iob_avalid_o,
  output logic [AXI_ADDR_W-1:0]   iob_addr_o,
  output logic [AXI_DATA_W-1:0]   iob_wdata_o,
  output logic [AXI_DATA_W/8-1:0] iob_wstrb_o,
  input  logic                    iob_rvalid_i,
  input  logic [AXI_DATA_W-1:0]   iob_rdata_i,
  input  logic                    iob_ready_i
);

  localparam int BEAT_B = beat_bytes(AXI_DATA_W);

  state_t state;
  logic   rd_pending;

  logic                  aw_hs, ar_hs, w_hs, w_drop, nat_hs, wr_done, r_hs;
  logic                  ctr_load, ctr_inc, ctr_dec, ctr_zero;
  logic [AXI_ADDR_W-1:0] load_addr;
  logic [AXI_LEN_W-1:0]  load_len;

  assign aw_hs   = (state == ST_IDLE) && axi_awready_o && axi_awvalid_i;
  assign ar_hs   = (state == ST_IDLE) && axi_arready_o && axi_arvalid_i;
  assign w_hs    = (state == ST_WR) && axi_wready_o && axi_wvalid_i;
  assign w_drop  = w_hs && (axi_wstrb_i == '0);
  assign nat_hs  = iob_avalid_o && iob_ready_i;
  // A zero-strobe beat retires its address slot immediately, exactly as if written.
  assign wr_done = (state == ST_WR) && (nat_hs || w_drop);
  assign r_hs    = (state == ST_RD) && axi_rvalid_o && axi_rready_i;

  assign ctr_load  = aw_hs || ar_hs;
  assign load_addr = aw_hs ? axi_awaddr_i : axi_araddr_i;
  assign load_len  = aw_hs ? axi_awlen_i : axi_arlen_i;
  assign ctr_inc   = wr_done || ((state == ST_RD) && nat_hs);
  assign ctr_dec   = (wr_done || r_hs) && !ctr_zero;

  iob_cache_axi_resp_ctr #(
    .ADDR_W (AXI_ADDR_W),
    .LEN_W  (AXI_LEN_W),
    .STEP   (BEAT_B)
  ) u_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (ctr_load),
    .load_addr (load_addr),
    .load_len  (load_len),
    .addr_inc  (ctr_inc),
    .cnt_dec   (ctr_dec),
    .addr      (iob_addr_o),
    .cnt_zero  (ctr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      rd_pending    <= 1'b0;
      axi_awready_o <= 1'b0;
      axi_arready_o <= 1'b0;
      axi_wready_o  <= 1'b0;
      axi_bvalid_o  <= 1'b0;
      axi_rvalid_o  <= 1'b0;
      axi_rlast_o   <= 1'b0;
      axi_rdata_o   <= '0;
      iob_avalid_o  <= 1'b0;
      iob_wdata_o   <= '0;
      iob_wstrb_o   <= '0;
    end else begin
      // Address-channel readies are single-cycle pulses.
      axi_awready_o <= 1'b0;
      axi_arready_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            state        <= ST_WR;
            axi_wready_o <= 1'b1;
          end else if (ar_hs) begin
            state <= ST_RD;
          end else if (!axi_awready_o && !axi_arready_o) begin
            if (axi_awvalid_i)      axi_awready_o <= 1'b1;
            else if (axi_arvalid_i) axi_arready_o <= 1'b1;
          end
        end
        ST_WR: begin
          if (w_hs && !w_drop) begin
            iob_avalid_o <= 1'b1;
            iob_wdata_o  <= axi_wdata_i;
            iob_wstrb_o  <= axi_wstrb_i;
            axi_wready_o <= 1'b0;
          end
          if (nat_hs) begin
            iob_avalid_o <= 1'b0;
            iob_wstrb_o  <= '0;
          end
          if (wr_done) begin
            if (ctr_zero) begin
              state        <= ST_WR_B;
              axi_wready_o <= 1'b0;
              axi_bvalid_o <= 1'b1;
            end else begin
              axi_wready_o <= 1'b1;
            end
          end
        end
        ST_WR_B: begin
          if (axi_bready_i) begin
            axi_bvalid_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (!iob_avalid_o && !rd_pending && !axi_rvalid_o) iob_avalid_o <= 1'b1;
          if (nat_hs) begin
            iob_avalid_o <= 1'b0;
            rd_pending   <= 1'b1;
          end
          if (rd_pending && iob_rvalid_i) begin
            rd_pending   <= 1'b0;
            axi_rvalid_o <= 1'b1;
            axi_rdata_o  <= iob_rdata_i;
            axi_rlast_o  <= ctr_zero;
          end
          if (r_hs) begin
            axi_rvalid_o <= 1'b0;
            axi_rlast_o  <= 1'b0;
            if (ctr_zero) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
